// File: rtl/sprite_x_store.sv
// sprite_x_store: parametrised sprite X store and matcher.
//
// During the OAM scan, qualifying sprites are allocated to slots in arrival
// order. Each slot stores X, OAM index and line offset. During pixel output
// the pixel X counter is compared against every valid slot. Matches are
// served lowest-slot-first through a req/ack fetch handshake. A served slot
// is invalidated, so sprites that share an X drain one per handshake while
// stall holds the pixel pipe.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   line_start            per-scanline pulse, clears the store and aborts fetches
//   scan_valid/x/id/line  OAM scan entry to allocate
//   pix_valid, pix_x      live pixel X counter
//   fetch_ack             fetcher consumed the pending request
//   fetch_req/id/line/slot registered fetch request
//   stall                 pixel pipe must hold pix_x
//   hit_mask              per-slot match vector
//   count, full           allocation count and saturation flag
//   overflow              sticky, a qualifying entry was dropped

// One storage slot with its own X comparator.
module sprite_x_slot #(
    parameter int XW  = 8,
    parameter int IDW = 6,
    parameter int LW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           wr,
    input  logic           inv,
    input  logic [XW-1:0]  wx,
    input  logic [IDW-1:0] wid,
    input  logic [LW-1:0]  wline,
    input  logic           pix_valid,
    input  logic [XW-1:0]  pix_x,
    output logic           hit,
    output logic [IDW-1:0] id,
    output logic [LW-1:0]  line
);
    logic          valid;
    logic [XW-1:0] x;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            x     <= '0;
            id    <= '0;
            line  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            x     <= wx;
            id    <= wid;
            line  <= wline;
        end else if (inv) begin
            valid <= 1'b0;
        end
    end

    assign hit = valid & (x == pix_x) & pix_valid;
endmodule

module sprite_x_store #(
    parameter int SLOTS = 10,
    parameter int XW    = 8,
    parameter int IDW   = 6,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic             scan_valid,
    input  logic [XW-1:0]    scan_x,
    input  logic [IDW-1:0]   scan_id,
    input  logic [LW-1:0]    scan_line,
    input  logic             pix_valid,
    input  logic [XW-1:0]    pix_x,
    input  logic             fetch_ack,
    output logic             fetch_req,
    output logic [IDW-1:0]   fetch_id,
    output logic [LW-1:0]    fetch_line,
    output logic [3:0]       fetch_slot,
    output logic             stall,
    output logic [SLOTS-1:0] hit_mask,
    output logic [4:0]       count,
    output logic             full,
    output logic             overflow
);
    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [LW-1:0]  line;
        logic [3:0]     slot;
    } fetch_t;

    state_t                    state;
    fetch_t                    fr;
    logic [SLOTS-1:0]          raw_hit;
    logic [SLOTS-1:0][IDW-1:0] s_id;
    logic [SLOTS-1:0][LW-1:0]  s_line;
    logic                      alloc, serve, any_hit;
    fetch_t                    sel;

    assign full  = (count == 5'(SLOTS));
    // line_start wins over a same-cycle scan entry or ack; both are dropped.
    assign alloc = scan_valid & ~full & ~line_start & ~reset;
    assign serve = (state == REQ) & fetch_ack & ~line_start & ~reset;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sprite_x_slot #(.XW(XW), .IDW(IDW), .LW(LW)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clr       (line_start),
            .wr        (alloc && count == 5'(g)),
            .inv       (serve && fr.slot == 4'(g)),
            .wx        (scan_x),
            .wid       (scan_id),
            .wline     (scan_line),
            .pix_valid (pix_valid),
            .pix_x     (pix_x),
            .hit       (raw_hit[g]),
            .id        (s_id[g]),
            .line      (s_line[g])
        );
    end

    // pix_valid is ignored in the reset cycle.
    assign hit_mask = reset ? '0 : raw_hit;
    assign any_hit  = |hit_mask;

    // Lowest set slot wins: scan high-to-low so the last assignment is lowest.
    always_comb begin
        sel = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (hit_mask[i]) begin
                sel.id   = s_id[i];
                sel.line = s_line[i];
                sel.slot = 4'(i);
            end
        end
    end

    // The IDLE term lets the pipe hold pix_x in the cycle a hit is first seen.
    assign stall = ~reset & (((state == IDLE) & any_hit) | (state == REQ));

    always_ff @(posedge clk) begin
        if (reset || line_start) begin
            state     <= IDLE;
            fetch_req <= 1'b0;
            fr        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (scan_valid) begin
                if (!full) count    <= count + 5'd1;
                else       overflow <= 1'b1;
            end
            case (state)
                IDLE: if (any_hit) begin
                    fr        <= sel;
                    fetch_req <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (fetch_ack) begin
                    fetch_req <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fetch_id   = fr.id;
    assign fetch_line = fr.line;
    assign fetch_slot = fr.slot;
endmodule

// File: tb/tb_sprite_x_store.sv
// Randomised scoreboard bench for sprite_x_store. The reference model tracks
// stored sprites as plain arrays; presenting a pixel X queues every stored,
// unserved sprite at that X in slot order. A monitor pops one entry per
// observed handshake.
module tb_sprite_x_store;
    localparam int SLOTS = 10;
    localparam int XW    = 8;
    localparam int IDW   = 6;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             reset, line_start, scan_valid, pix_valid, fetch_ack;
    logic [XW-1:0]    scan_x, pix_x;
    logic [IDW-1:0]   scan_id;
    logic [LW-1:0]    scan_line;
    logic             fetch_req, stall, full, overflow;
    logic [IDW-1:0]   fetch_id;
    logic [LW-1:0]    fetch_line;
    logic [3:0]       fetch_slot;
    logic [SLOTS-1:0] hit_mask;
    logic [4:0]       count;

    int checks = 0;
    int errors = 0;
    bit auto_ack = 1'b0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [LW-1:0]  line;
        logic [3:0]     slot;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [XW-1:0]  m_x    [SLOTS];
    logic [IDW-1:0] m_id   [SLOTS];
    logic [LW-1:0]  m_line [SLOTS];
    bit             m_v    [SLOTS];
    int             m_cnt;
    bit             m_ovf;

    sprite_x_store #(.SLOTS(SLOTS), .XW(XW), .IDW(IDW), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .scan_valid (scan_valid),
        .scan_x     (scan_x),
        .scan_id    (scan_id),
        .scan_line  (scan_line),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .fetch_ack  (fetch_ack),
        .fetch_req  (fetch_req),
        .fetch_id   (fetch_id),
        .fetch_line (fetch_line),
        .fetch_slot (fetch_slot),
        .stall      (stall),
        .hit_mask   (hit_mask),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < SLOTS; i++) m_v[i] = 1'b0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void m_scan(input logic [XW-1:0] x, input logic [IDW-1:0] id,
                                   input logic [LW-1:0] ln);
        if (m_cnt < SLOTS) begin
            m_x[m_cnt] = x; m_id[m_cnt] = id; m_line[m_cnt] = ln; m_v[m_cnt] = 1'b1;
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    // Returns the expected hit vector and queues the fetches it will produce.
    function automatic logic [SLOTS-1:0] m_pix(input logic [XW-1:0] px);
        logic [SLOTS-1:0] mask = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_v[i] && m_x[i] == px) begin
                mask[i] = 1'b1;
                sb.push_back('{id: m_id[i], line: m_line[i], slot: 4'(i)});
                m_v[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_line_start();
        line_start = 1'b1;
        m_clear();
        tick();
        line_start = 1'b0;
    endtask

    task automatic do_scan(input logic [XW-1:0] x, input logic [IDW-1:0] id, input logic [LW-1:0] ln);
        scan_valid = 1'b1; scan_x = x; scan_id = id; scan_line = ln;
        m_scan(x, id, ln);
        tick();
        scan_valid = 1'b0;
    endtask

    // Present px and hold it until stall drops; every queued fetch must have drained.
    task automatic drive_pix(input logic [XW-1:0] px);
        logic [SLOTS-1:0] mask;
        int n = 0;
        mask = m_pix(px);
        pix_x = px; pix_valid = 1'b1;
        @(negedge clk);
        chk("pix_hit_mask", hit_mask, mask);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL stall_timeout px=%0d", px);
        end
        chk("drain_queue_size", sb.size(), 0);
        sb.delete();
        tick();
        pix_valid = 1'b0;
    endtask

    // Auto acker: random acks, including ones outside REQ that must be ignored.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_ack) fetch_ack = ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk) begin
        if (fetch_req && fetch_ack && !reset && !line_start) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected id=%0d line=%0d slot=%0d", fetch_id, fetch_line, fetch_slot);
            end else begin
                mon_e = sb.pop_front();
                if (fetch_id !== mon_e.id || fetch_line !== mon_e.line || fetch_slot !== mon_e.slot) begin
                    errors++;
                    $display("FAIL fetch_data actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                             fetch_id, fetch_line, fetch_slot, mon_e.id, mon_e.line, mon_e.slot);
                end
            end
        end
    end

    initial begin
        logic [SLOTS-1:0] mask;
        int n;
        reset = 1'b1; line_start = 1'b0; scan_valid = 1'b0; scan_x = '0; scan_id = '0;
        scan_line = '0; pix_valid = 1'b0; pix_x = '0; fetch_ack = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_full", full, 0);
        reset = 1'b0;

        // Reset while a stored slot matches and a scan entry is offered.
        do_scan(8'd40, 6'd1, 4'd1);
        chk("pre_rst_count", count, 1);
        reset = 1'b1; scan_valid = 1'b1; scan_x = 8'd41; pix_valid = 1'b1; pix_x = 8'd40;
        @(negedge clk);
        chk("rst_hit_mask", hit_mask, 0);
        chk("rst_stall_hit", stall, 0);
        tick();
        m_clear();
        chk("rst2_count", count, 0);
        chk("rst2_fetch_req", fetch_req, 0);
        reset = 1'b0; scan_valid = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        chk("rst_overflow", overflow, 0);
        chk("rst_hit_after", hit_mask, 0);
        tick();

        // Allocation and overflow: 12 entries into 10 slots.
        auto_ack = 1'b1;
        do_line_start();
        for (int i = 0; i < 12; i++) begin
            scan_valid = 1'b1; scan_x = XW'(8 + i); scan_id = IDW'(i); scan_line = LW'(i);
            m_scan(scan_x, scan_id, scan_line);
            @(negedge clk);
            if (i == 10) chk("ovf_before", overflow, 0);
            tick();
            if (i == 10) chk("ovf_after", overflow, 1);
        end
        scan_valid = 1'b0;
        chk("ovf_count", count, 10);
        chk("ovf_full", full, 1);
        chk("ovf_sticky", overflow, 1);
        for (int px = 0; px < 26; px++) drive_pix(XW'(px));

        // Single match with a hand-timed ack in the third REQ cycle.
        auto_ack = 1'b0; fetch_ack = 1'b0;
        do_line_start();
        do_scan(8'd40, 6'd5, 4'd3);
        for (int px = 36; px < 40; px++) drive_pix(XW'(px));
        mask = m_pix(8'd40);
        pix_x = 8'd40; pix_valid = 1'b1;
        @(negedge clk);
        chk("sm_hit_mask", hit_mask, mask);
        chk("sm_stall_same_cycle", stall, 1);
        chk("sm_req_not_yet", fetch_req, 0);
        tick();
        chk("sm_req", fetch_req, 1);
        chk("sm_id", fetch_id, 5);
        chk("sm_line", fetch_line, 3);
        chk("sm_slot", fetch_slot, 0);
        tick();
        tick();
        chk("sm_req_held", fetch_req, 1);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        chk("sm_req_done", fetch_req, 0);
        chk("sm_stall_done", stall, 0);
        chk("sm_no_rematch", hit_mask, 0);
        chk("sm_queue", sb.size(), 0);
        pix_valid = 1'b0;
        tick();
        auto_ack = 1'b1;
        for (int px = 38; px < 43; px++) drive_pix(XW'(px));

        // Same-X priority: slots 2, 4, 7 at x=16.
        do_line_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 2)      do_scan(8'd16, 6'd9, 4'd1);
            else if (i == 4) do_scan(8'd16, 6'd3, 4'd2);
            else if (i == 7) do_scan(8'd16, 6'd20, 4'd3);
            else             do_scan(XW'(60 + i), IDW'(40 + i), LW'(i));
        end
        drive_pix(8'd16);
        drive_pix(8'd16);

        // Abort: line_start while a request is pending.
        auto_ack = 1'b0; fetch_ack = 1'b0;
        do_line_start();
        do_scan(8'd30, 6'd7, 4'd2);
        pix_x = 8'd30; pix_valid = 1'b1;
        tick();
        chk("ab_req", fetch_req, 1);
        line_start = 1'b1; pix_valid = 1'b0;
        tick();
        line_start = 1'b0;
        m_clear();
        chk("ab_req_off", fetch_req, 0);
        chk("ab_count", count, 0);
        chk("ab_stall", stall, 0);
        auto_ack = 1'b1;
        for (int px = 25; px < 36; px++) drive_pix(XW'(px));

        // Allocation and match in the same cycle.
        do_line_start();
        pix_x = 8'd50; pix_valid = 1'b1;
        scan_valid = 1'b1; scan_x = 8'd50; scan_id = 6'd33; scan_line = 4'd9;
        mask = m_pix(8'd50);
        m_scan(8'd50, 6'd33, 4'd9);
        @(negedge clk);
        chk("sim_hit_mask", hit_mask, mask);
        chk("sim_stall", stall, 0);
        tick();
        scan_valid = 1'b0;
        drive_pix(8'd50);

        // Randomised lines.
        for (int l = 0; l < 15; l++) begin
            do_line_start();
            n = $urandom_range(0, 14);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                do_scan(XW'($urandom_range(0, 31)), IDW'($urandom), LW'($urandom));
            end
            chk("rnd_count", count, m_cnt);
            chk("rnd_full", full, (m_cnt == SLOTS));
            chk("rnd_overflow", overflow, m_ovf);
            for (int px = 0; px < 34; px++) begin
                if ($urandom_range(0, 3) == 0) begin
                    pix_valid = 1'b0; pix_x = XW'($urandom_range(0, 31));
                    @(negedge clk);
                    chk("gap_hit_mask", hit_mask, 0);
                    chk("gap_stall", stall, 0);
                    tick();
                end
                drive_pix(XW'(px));
            end
        end

        auto_ack = 1'b0; fetch_ack = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
